instruction_fetch_unit: RTL

- Fetch-side initiator for the program memory request/ack interface.
- Generates sequential PCs from a reset vector and drives one request at a time.
- Captures each acknowledged instruction into a small prefetch FIFO and presents instructions in order to decode with a valid/ready handshake.
- Supports redirect (branch/jump/trap) with a full flush of buffered and in-flight fetches.

---
 rtl/instruction_fetch_unit.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch-side initiator for a request/ack program memory. Generates sequential
// word-aligned PCs starting at RESET_VECTOR and keeps at most one request
// outstanding. Each acknowledged word is captured with its PC into a small
// prefetch FIFO. The FIFO head is offered to decode through a valid/ready
// handshake. A redirect flushes everything and restarts fetch at a new PC.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   When defined, a request left unacknowledged for TIMEOUT cycles raises a
//   sticky or_fetch_fault and drops the request. Only a redirect or a reset
//   clears the fault. When the macro is undefined, or_fetch_fault is 0.
//
// Ports:
//   i_clk                   clock; all state changes on the rising edge
//   i_rst_n                 synchronous active-low reset
//   or_pc                   fetch address (registered)
//   or_instruction_request  fetch request (registered)
//   i_instruction           instruction data from memory
//   i_ack                   memory acknowledge (may be same-cycle)
//   o_inst_valid            FIFO head valid
//   o_inst                  FIFO head instruction
//   o_inst_pc               FIFO head PC
//   i_inst_ready            decode accepts the head
//   i_redirect              flush and restart fetch
//   i_redirect_pc           restart address (low two bits ignored)
//   or_fetch_fault          sticky timeout fault
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] or_pc,
  output logic        or_instruction_request,
  input  logic [31:0] i_instruction,
  input  logic        i_ack,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        or_fetch_fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          req_q, req_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_inst_q [DEPTH];
  logic [31:0]   mem_pc_q   [DEPTH];

  logic          push_s;
  logic          pop_s;
  logic          timeout_s;
  logic [CW-1:0] count_next_s;
  logic          unused_s;

  // A redirect in the same cycle cancels both the capture and the pop.
  assign push_s       = req_q && i_ack && !i_redirect;
  assign pop_s        = (count_q != '0) && i_inst_ready && !i_redirect;
  assign count_next_s = count_q + CW'(push_s) - CW'(pop_s);

  // Fetch addresses are always word aligned.
  assign unused_s = ^i_redirect_pc[1:0];

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Count consecutive waiting cycles; fire when the TIMEOUT-th one elapses.
  always_comb begin
    tmo_d     = tmo_q;
    timeout_s = 1'b0;
    if (i_redirect || (req_q && i_ack)) begin
      tmo_d = '0;
    end else if (req_q) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        timeout_s = 1'b1;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Timeout counter register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo_s;
  assign timeout_s    = 1'b0;
  assign unused_tmo_s = TIMEOUT[0];
`endif

  // Next-state logic for the fetch FSM, PC, request, fault and FIFO pointers.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    fault_d  = fault_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pc_d     = {i_redirect_pc[31:2], 2'b00};
      req_d    = 1'b1;
      fault_d  = 1'b0;
      state_d  = S_FETCH;
    end else begin
      count_d  = count_next_s;
      wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
      pc_d     = push_s ? pc_q + 32'd4 : pc_q;
      case (state_q)
        S_START: begin
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
        S_FETCH, S_FULL: begin
          // Request is lowered when full, so a push can never overflow.
          if (timeout_s) begin
            req_d   = 1'b0;
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else if (count_next_s == DEPTH_C) begin
            req_d   = 1'b0;
            state_d = S_FULL;
          end else begin
            req_d   = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_FAULT: begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end
        default: begin
          req_d   = 1'b0;
          state_d = S_START;
        end
      endcase
    end
  end

  // Control and pointer registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_START;
      pc_q     <= RESET_VECTOR;
      req_q    <= 1'b0;
      fault_q  <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents only matter while counted, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_inst_q[wr_ptr_q] <= i_instruction;
      mem_pc_q[wr_ptr_q]   <= pc_q;
    end
  end

  assign or_pc                  = pc_q;
  assign or_instruction_request = req_q;
  assign or_fetch_fault         = fault_q;
  assign o_inst_valid           = (count_q != '0);
  assign o_inst                 = mem_inst_q[rd_ptr_q];
  assign o_inst_pc              = mem_pc_q[rd_ptr_q];

endmodule
